goertzel_singlebin_synth: RTL and testbench

Single-bin inverse-DFT synthesizer, the transmit-side counterpart of the single-bin Goertzel analyzer.
- Takes one complex bin coefficient (re, im), bin index k and length N = 2^i_N.
- Streams the N real time-domain samples x[n] = re·cos(2πkn/N) − im·sin(2πkn/N) over a valid/ready interface.
- Uses a second-order recursive oscillator and the same full-period cos/sine ROM format as the analyzer.

---
 rtl/goertzel_singlebin_synth_if.sv | 27 ++
 rtl/goertzel_singlebin_synth.sv | 153 +++++++++++++++
 tb/tb_goertzel_singlebin_synth.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/goertzel_singlebin_synth_if.sv
// Control and sample-stream bundle for the single-bin synthesizer.
// The master side starts a synthesis run and consumes samples; the slave side is the synthesizer.
interface goertzel_singlebin_synth_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LOG_N_MAX = 5
);
    logic                               i_start;
    logic signed [WIDTH-1:0]            i_re;
    logic signed [WIDTH-1:0]            i_im;
    logic [LOG_N_MAX-1:0]               i_k;
    logic [$clog2(LOG_N_MAX):0]         i_N;
    logic                               o_busy;
    logic signed [WIDTH-1:0]            o_x;
    logic                               o_valid;
    logic                               i_ready;
    logic                               o_last;

    modport master (
        output i_start, i_re, i_im, i_k, i_N, i_ready,
        input  o_busy, o_x, o_valid, o_last
    );

    modport slave (
        input  i_start, i_re, i_im, i_k, i_N, i_ready,
        output o_busy, o_x, o_valid, o_last
    );
endinterface

// File: rtl/goertzel_singlebin_synth.sv
// Single-bin inverse-DFT synthesizer: streams x[n] = re*cos(2*pi*k*n/N) - im*sin(2*pi*k*n/N)
// from a second-order recursive oscillator seeded with the first two samples.
module goertzel_singlebin_synth #(
    parameter int unsigned N_MAX     = 32,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned LOG_N_MAX = $clog2(N_MAX),
    parameter int unsigned GUARD     = 4
) (
    input  logic                         i_sys_clk,
    input  logic                         i_sys_rst_n,
    goertzel_singlebin_synth_if.slave    bus
);
    localparam int unsigned SW = WIDTH + GUARD;
    localparam int unsigned PW = SW + WIDTH;
    localparam int unsigned NW = $clog2(LOG_N_MAX) + 1;
    localparam real         PI = 3.14159265358979323846;

    localparam logic signed [WIDTH-1:0] X_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] X_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]    SAT_HI = SW'(X_MAX);
    localparam logic signed [SW-1:0]    SAT_LO = SW'(X_MIN);

    typedef enum logic [1:0] {IDLE, LOAD, RUN0, RUN} state_e;

    // Full-period table entry round(trig(2*pi*j/N_MAX) * 2^FRAC_BITS), evaluated at elaboration.
    function automatic int trig_entry(input int unsigned j, input bit want_sin);
        real th, term, acc, scale;
        th = 2.0 * PI * j / N_MAX;
        if (th > PI) th = th - 2.0 * PI;
        scale = 1.0;
        for (int unsigned i = 0; i < FRAC_BITS; i++) scale = scale * 2.0;
        term = want_sin ? th : 1.0;
        acc  = term;
        for (int unsigned i = 1; i < 20; i++) begin
            if (want_sin) term = -term * th * th / ((2.0 * i) * (2.0 * i + 1.0));
            else          term = -term * th * th / ((2.0 * i - 1.0) * (2.0 * i));
            acc = acc + term;
        end
        acc = acc * scale;
        return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI)      return X_MAX;
        else if (v < SAT_LO) return X_MIN;
        else                 return v[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] cos_rom [N_MAX];
    logic signed [WIDTH-1:0] sin_rom [N_MAX];

    for (genvar g = 0; g < N_MAX; g++) begin : g_rom
        localparam int CV = trig_entry(g, 1'b0);
        localparam int SV = trig_entry(g, 1'b1);
        assign cos_rom[g] = WIDTH'(CV);
        assign sin_rom[g] = WIDTH'(SV);
    end

    state_e                  state_q;
    logic signed [WIDTH-1:0] re_q, im_q, c_q, s_q, x_q;
    logic [LOG_N_MAX-1:0]    k_q, n_q;
    logic [NW-1:0]           neff_q;
    logic signed [SW-1:0]    y0_q, y1_q;
    logic                    busy_q, valid_q, last_q;

    logic [NW-1:0]           neff_d;
    logic [LOG_N_MAX-1:0]    rom_idx, n_last;
    logic [LOG_N_MAX:0]      span;
    logic signed [PW-1:0]    re_c, im_s, osc_prod;
    logic signed [SW-1:0]    s1_d, y_new_d;

    always_comb begin
        neff_d   = (bus.i_N > NW'(LOG_N_MAX)) ? NW'(LOG_N_MAX) : bus.i_N;
        rom_idx  = k_q << (NW'(LOG_N_MAX) - neff_q);
        span     = (LOG_N_MAX+1)'(1) << neff_q;
        n_last   = LOG_N_MAX'(span - 1'b1);
        re_c     = PW'(re_q) * PW'(c_q);
        im_s     = PW'(im_q) * PW'(s_q);
        osc_prod = PW'(c_q) * PW'(y0_q);
        // Wide arithmetic first, then wrap into the guard-extended state width.
        s1_d     = SW'((re_c >>> FRAC_BITS) - (im_s >>> FRAC_BITS));
        y_new_d  = SW'(((osc_prod <<< 1) >>> FRAC_BITS) - PW'(y1_q));
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= IDLE;
            re_q    <= '0;
            im_q    <= '0;
            k_q     <= '0;
            neff_q  <= '0;
            c_q     <= '0;
            s_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            n_q     <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            c_q <= cos_rom[rom_idx];
            s_q <= sin_rom[rom_idx];
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        re_q    <= bus.i_re;
                        im_q    <= bus.i_im;
                        k_q     <= bus.i_k;
                        neff_q  <= neff_d;
                        n_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: state_q <= RUN0;
                RUN0: begin
                    y1_q    <= SW'(re_q);
                    y0_q    <= s1_d;
                    x_q     <= re_q;
                    n_q     <= '0;
                    valid_q <= 1'b1;
                    last_q  <= (neff_q == '0);
                    state_q <= RUN;
                end
                RUN: begin
                    if (valid_q && bus.i_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            // y0 already holds the sample for the incremented index.
                            x_q    <= sat(y0_q);
                            y1_q   <= y0_q;
                            y0_q   <= y_new_d;
                            n_q    <= n_q + 1'b1;
                            last_q <= ((n_q + 1'b1) == n_last);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_x     = x_q;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
endmodule

// File: tb/tb_goertzel_singlebin_synth.sv
// Directed bench for goertzel_singlebin_synth with hand-computed sample sequences.
module tb_goertzel_singlebin_synth;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    goertzel_singlebin_synth_if #(.WIDTH(16), .LOG_N_MAX(5)) bus ();

    goertzel_singlebin_synth #(
        .N_MAX(32), .WIDTH(16), .FRAC_BITS(4), .GUARD(4)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic signed [15:0] re, input logic signed [15:0] im,
                            input logic [4:0] k, input logic [3:0] n);
        @(negedge clk);
        bus.i_re = re; bus.i_im = im; bus.i_k = k; bus.i_N = n; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.o_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_re = '0; bus.i_im = '0; bus.i_k = '0; bus.i_N = '0; bus.i_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.o_busy); end
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", bus.o_last); end
        checks++; if (bus.o_x !== 16'sd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", bus.o_x); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic signed [15:0] exp [4] = '{16'sd50, -16'sd20, -16'sd50, 16'sd20};
        int cyc;
        do_start(50, 20, 1, 2);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%0b exp=1", bus.o_busy); end
        wait_valid(cyc);
        checks++; if (cyc != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_x !== exp[i]) begin failures++; $display("FAIL basic_x[%0d] got=%0d exp=%0d", i, bus.o_x, exp[i]); end
            checks++; if (bus.o_last !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 3)); end
            checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%0b exp=1", i, bus.o_valid); end
            @(negedge clk);
        end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_end got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%0b exp=0", bus.o_busy); end
    endtask

    task automatic test_two_point_and_dc();
        int cyc;
        logic signed [15:0] exp2 [2] = '{16'sd100, -16'sd100};
        do_start(100, 0, 1, 1);
        wait_valid(cyc);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.o_x !== exp2[i]) begin failures++; $display("FAIL n2_x[%0d] got=%0d exp=%0d", i, bus.o_x, exp2[i]); end
            checks++; if (bus.o_last !== (i == 1)) begin failures++; $display("FAIL n2_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 1)); end
            @(negedge clk);
        end
        do_start(-7, 0, 0, 3);
        wait_valid(cyc);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.o_x !== -16'sd7) begin failures++; $display("FAIL dc_x[%0d] got=%0d exp=-7", i, bus.o_x); end
            checks++; if (bus.o_last !== (i == 7)) begin failures++; $display("FAIL dc_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 7)); end
            @(negedge clk);
        end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL dc_valid_end got=%0b exp=0", bus.o_valid); end
    endtask

    task automatic test_len_clamp();
        int cyc;
        int n = 0;
        do_start(3, 0, 0, 7);
        wait_valid(cyc);
        while (bus.o_valid === 1'b1 && n < 40) begin
            checks++; if (bus.o_x !== 16'sd3) begin failures++; $display("FAIL clamp_x[%0d] got=%0d exp=3", n, bus.o_x); end
            checks++; if (bus.o_last !== (n == 31)) begin failures++; $display("FAIL clamp_last[%0d] got=%0b exp=%0b", n, bus.o_last, (n == 31)); end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 32) begin failures++; $display("FAIL clamp_count got=%0d exp=32", n); end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] exp [4] = '{16'sd50, -16'sd20, -16'sd50, 16'sd20};
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic signed [15:0] hx;
        logic hl, r;
        logic hold = 1'b0;
        int cyc, idx = 0, t = 0;
        do_start(50, 20, 1, 2);
        wait_valid(cyc);
        while (idx < 4 && t < 30) begin
            checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", t, bus.o_valid); end
            if (hold) begin
                checks++; if (bus.o_x !== hx) begin failures++; $display("FAIL bp_hold_x[%0d] got=%0d exp=%0d", t, bus.o_x, hx); end
                checks++; if (bus.o_last !== hl) begin failures++; $display("FAIL bp_hold_last[%0d] got=%0b exp=%0b", t, bus.o_last, hl); end
            end
            r = (t < 7) ? pat[t] : 1'b1;
            bus.i_ready = r;
            if (r) begin
                checks++; if (bus.o_x !== exp[idx]) begin failures++; $display("FAIL bp_x[%0d] got=%0d exp=%0d", idx, bus.o_x, exp[idx]); end
                checks++; if (bus.o_last !== (idx == 3)) begin failures++; $display("FAIL bp_last[%0d] got=%0b exp=%0b", idx, bus.o_last, (idx == 3)); end
                idx++;
                hold = 1'b0;
            end else begin
                hold = 1'b1; hx = bus.o_x; hl = bus.o_last;
            end
            @(negedge clk);
            t++;
        end
        bus.i_ready = 1'b1;
        checks++; if (t != 7) begin failures++; $display("FAIL bp_cycles got=%0d exp=7", t); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_end got=%0b exp=0", bus.o_valid); end
    endtask

    task automatic test_single_and_ignore();
        logic signed [15:0] exp [4] = '{16'sd50, -16'sd20, -16'sd50, 16'sd20};
        int cyc;
        do_start(-32768, 0, 0, 0);
        wait_valid(cyc);
        checks++; if (bus.o_x !== -16'sd32768) begin failures++; $display("FAIL single_x got=%0d exp=-32768", bus.o_x); end
        checks++; if (bus.o_last !== 1'b1) begin failures++; $display("FAIL single_last got=%0b exp=1", bus.o_last); end
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0b exp=0", bus.o_busy); end
        do_start(50, 20, 1, 2);
        wait_valid(cyc);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_x !== exp[i]) begin failures++; $display("FAIL ign_x[%0d] got=%0d exp=%0d", i, bus.o_x, exp[i]); end
            checks++; if (bus.o_last !== (i == 3)) begin failures++; $display("FAIL ign_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 3)); end
            if (i == 1) begin
                bus.i_start = 1'b1; bus.i_re = 16'sd5; bus.i_im = 16'sd0; bus.i_k = 5'd0; bus.i_N = 4'd3;
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL ign_busy_after got=%0b exp=0", bus.o_busy); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp [8] = '{16'sd32767, 16'sd32767, 16'sd29183, -16'sd4929,
                                        -16'sd32768, -16'sd32768, -16'sd25252, 16'sd9796};
        int cyc;
        do_start(32767, -32767, 1, 3);
        wait_valid(cyc);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.o_x !== exp[i]) begin failures++; $display("FAIL sat_x[%0d] got=%0d exp=%0d", i, bus.o_x, exp[i]); end
            checks++; if (bus.o_last !== (i == 7)) begin failures++; $display("FAIL sat_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 7)); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset_mid();
        logic signed [15:0] exp [4] = '{16'sd50, -16'sd20, -16'sd50, 16'sd20};
        int cyc;
        do_start(50, 20, 1, 2);
        wait_valid(cyc);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", bus.o_busy); end
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL arst_last got=%0b exp=0", bus.o_last); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL arst_no_resume got=%0b exp=0", bus.o_valid); end
        do_start(50, 20, 1, 2);
        wait_valid(cyc);
        checks++; if (cyc != 2) begin failures++; $display("FAIL arst_latency got=%0d exp=2", cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_x !== exp[i]) begin failures++; $display("FAIL arst_x[%0d] got=%0d exp=%0d", i, bus.o_x, exp[i]); end
            checks++; if (bus.o_last !== (i == 3)) begin failures++; $display("FAIL arst_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 3)); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_start(100, 0, 1, 1);
        wait_valid(cyc);
        repeat (2) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_gap got=%0b exp=0", bus.o_busy); end
        bus.i_re = -16'sd7; bus.i_im = 16'sd0; bus.i_k = 5'd0; bus.i_N = 4'd1; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_restart got=%0b exp=1", bus.o_busy); end
        wait_valid(cyc);
        checks++; if (cyc != 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", cyc); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.o_x !== -16'sd7) begin failures++; $display("FAIL b2b_x[%0d] got=%0d exp=-7", i, bus.o_x); end
            checks++; if (bus.o_last !== (i == 1)) begin failures++; $display("FAIL b2b_last[%0d] got=%0b exp=%0b", i, bus.o_last, (i == 1)); end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_two_point_and_dc();
        test_len_clamp();
        test_backpressure();
        test_single_and_ignore();
        test_saturation();
        test_async_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
